// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard unit.
package fwd_pkg;

   // Select code meaning "no bypass, read the register file".
   localparam int unsigned SEL_REGFILE = 0;

   // Control bits of the entry sitting in EX.
   typedef struct packed {
      logic valid;
      logic regwrite;
      logic is_load;
   } ex_flags_t;

   // Width of one select field: enough to encode 0..depth.
   function automatic int unsigned sel_width(input int unsigned depth);
      return (depth < 1) ? 1 : $clog2(depth + 1);
   endfunction

   // Select code that picks the result of bypass stage k.
   function automatic int unsigned sel_code(input int unsigned stage_k);
      return SEL_REGFILE + stage_k;
   endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Priority encoder for one source operand: finds the youngest later stage
// whose pending write targets this source register.
module fwd_src_match
   import fwd_pkg::*;
#(
   parameter int AW        = 5,
   parameter int FWD_DEPTH = 2,
   parameter int SEL_W     = 2
) (
   input  logic                    i_en,
   input  logic [AW-1:0]           i_rs,
   input  logic [FWD_DEPTH-1:0]    i_stg_wr,
   input  logic [FWD_DEPTH*AW-1:0] i_stg_rd,
   output logic [SEL_W-1:0]        o_sel
);

   // Scan oldest to youngest so the youngest matching stage overwrites older ones.
   always_comb begin
      o_sel = SEL_W'(SEL_REGFILE);
      if (i_en) begin
         for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (i_stg_wr[k-1] && (i_stg_rd[(k-1)*AW +: AW] == i_rs)) begin
               o_sel = SEL_W'(sel_code(k));
            end
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select generation and load-use stall detection. Keeps a shadow
// of the destination writes in EX and the FWD_DEPTH stages after it.
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter  int AW        = 5,
   parameter  int NUM_SRC   = 2,
   parameter  int FWD_DEPTH = 2,
   parameter  int CNT_W     = 32,
   localparam int SEL_W     = sel_width(FWD_DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     id_valid,
   input  logic [NUM_SRC*AW-1:0]    id_rs,
   input  logic [NUM_SRC-1:0]       id_rs_used,
   input  logic [AW-1:0]            id_rd,
   input  logic                     id_regwrite,
   input  logic                     id_is_load,
   input  logic                     flush,
   input  logic                     pipe_hold,
   output logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel,
   output logic                     stall_id,
   output logic [CNT_W-1:0]         stall_cnt
);

   // EX entry (stage 0)
   ex_flags_t                 r_ex_flags;
   logic [AW-1:0]             r_ex_rd;
   logic [NUM_SRC*AW-1:0]     r_ex_rs;
   logic [NUM_SRC-1:0]        r_ex_rs_used;

   // Later stages 1..FWD_DEPTH; stage k lives at bit k-1 / slice (k-1)*AW.
   // Only what forwarding consumes is kept once an entry leaves EX.
   logic [FWD_DEPTH-1:0]      r_stg_valid;
   logic [FWD_DEPTH-1:0]      r_stg_regwrite;
   logic [FWD_DEPTH*AW-1:0]   r_stg_rd;

   logic [CNT_W-1:0]          r_stall_cnt;

   logic                      w_bubble;
   logic [NUM_SRC-1:0]        w_load_hit;
   logic [FWD_DEPTH-1:0]      w_stg_wr;

   assign w_stg_wr = r_stg_valid & r_stg_regwrite;

   // Per-source forwarding select and load-use comparison against EX.
   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [AW-1:0] w_ex_rs;
      logic          w_en;
      logic [AW-1:0] w_id_rs;

      assign w_ex_rs = r_ex_rs[gi*AW +: AW];
      assign w_en    = r_ex_flags.valid & r_ex_rs_used[gi] & (w_ex_rs != '0);
      assign w_id_rs = id_rs[gi*AW +: AW];

      fwd_src_match #(
         .AW        (AW),
         .FWD_DEPTH (FWD_DEPTH),
         .SEL_W     (SEL_W)
      ) u_match (
         .i_en     (w_en),
         .i_rs     (w_ex_rs),
         .i_stg_wr (w_stg_wr),
         .i_stg_rd (r_stg_rd),
         .o_sel    (ex_fwd_sel[gi*SEL_W +: SEL_W])
      );

      assign w_load_hit[gi] = id_rs_used[gi] & (w_id_rs != '0) & (w_id_rs == r_ex_rd);
   end

   // Load in EX whose result the ID instruction needs; a flush kills ID instead.
   assign stall_id = id_valid & ~flush & r_ex_flags.valid & r_ex_flags.regwrite &
                     r_ex_flags.is_load & (|w_load_hit);

   assign w_bubble  = flush | stall_id | ~id_valid;
   assign stall_cnt = r_stall_cnt;

   // EX entry: capture ID or insert a bubble (all fields cleared) on advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex_flags   <= '0;
         r_ex_rd      <= '0;
         r_ex_rs      <= '0;
         r_ex_rs_used <= '0;
      end else if (!pipe_hold) begin
         if (w_bubble) begin
            r_ex_flags   <= '0;
            r_ex_rd      <= '0;
            r_ex_rs      <= '0;
            r_ex_rs_used <= '0;
         end else begin
            r_ex_flags   <= '{valid: 1'b1, regwrite: id_regwrite, is_load: id_is_load};
            r_ex_rd      <= id_rd;
            r_ex_rs      <= id_rs;
            r_ex_rs_used <= id_rs_used;
         end
      end
   end

   // Shift the in-flight writes down the bypass stages on advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stg_valid    <= '0;
         r_stg_regwrite <= '0;
         r_stg_rd       <= '0;
      end else if (!pipe_hold) begin
         r_stg_valid[0]    <= r_ex_flags.valid;
         r_stg_regwrite[0] <= r_ex_flags.regwrite;
         r_stg_rd[0 +: AW] <= r_ex_rd;
         for (int k = 1; k < FWD_DEPTH; k++) begin
            r_stg_valid[k]         <= r_stg_valid[k-1];
            r_stg_regwrite[k]      <= r_stg_regwrite[k-1];
            r_stg_rd[k*AW +: AW]   <= r_stg_rd[(k-1)*AW +: AW];
         end
      end
   end

   // Saturating count of stall cycles that actually took effect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (stall_id && !pipe_hold && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit (NUM_SRC=2, FWD_DEPTH=2, 2-bit stall counter).
module tb_fwd_hazard_unit;

   logic       clk;
   logic       rst_n;
   logic       id_valid;
   logic [9:0] id_rs;
   logic [1:0] id_rs_used;
   logic [4:0] id_rd;
   logic       id_regwrite;
   logic       id_is_load;
   logic       flush;
   logic       pipe_hold;
   logic [3:0] ex_fwd_sel;
   logic       stall_id;
   logic [1:0] stall_cnt;

   logic [1:0] sel0;
   logic [1:0] sel1;
   assign sel0 = ex_fwd_sel[1:0];
   assign sel1 = ex_fwd_sel[3:2];

   int vec;
   int err;

   fwd_hazard_unit #(
      .AW        (5),
      .NUM_SRC   (2),
      .FWD_DEPTH (2),
      .CNT_W     (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rs_used  (id_rs_used),
      .id_rd       (id_rd),
      .id_regwrite (id_regwrite),
      .id_is_load  (id_is_load),
      .flush       (flush),
      .pipe_hold   (pipe_hold),
      .ex_fwd_sel  (ex_fwd_sel),
      .stall_id    (stall_id),
      .stall_cnt   (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                        input logic [1:0] used, input logic [4:0] rd,
                        input logic rw, input logic ld);
      id_valid    = v;
      id_rs       = {r1, r0};
      id_rs_used  = used;
      id_rd       = rd;
      id_regwrite = rw;
      id_is_load  = ld;
   endtask

   task automatic idle(input int n);
      drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; pipe_hold = 1'b0;
      id_valid = 1'b0; id_rs = 'x; id_rs_used = 'x; id_rd = 'x;
      id_regwrite = 'x; id_is_load = 'x;
      #2;
      vec++; if (ex_fwd_sel !== 4'd0) begin err++; $display("FAIL reset_sel got=%b exp=0000", ex_fwd_sel); end
      vec++; if (stall_id !== 1'b0) begin err++; $display("FAIL reset_stall got=%b exp=0", stall_id); end
      vec++; if (stall_cnt !== 2'd0) begin err++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
      #1 rst_n = 1'b1;
      tick();
      vec++; if (ex_fwd_sel !== 4'd0 || stall_id !== 1'b0) begin err++; $display("FAIL idle_x_inputs sel=%b stall=%b exp sel=0000 stall=0", ex_fwd_sel, stall_id); end
      $display("reset: sel=%b stall=%b cnt=%0d", ex_fwd_sel, stall_id, stall_cnt);
      idle(1);
   endtask

   task automatic test_bypass();
      drive(1, 5'd1, 5'd2, 2'b11, 5'd5, 1, 0);           // add x5
      #1 vec++; if (stall_id !== 1'b0) begin err++; $display("FAIL bypass_stall_a got=%b exp=0", stall_id); end
      tick();
      drive(1, 5'd5, 5'd6, 2'b11, 5'd8, 1, 0);           // sub rs1=x5
      #1 vec++; if (stall_id !== 1'b0) begin err++; $display("FAIL bypass_stall_b got=%b exp=0", stall_id); end
      tick();
      vec++; if (sel0 !== 2'd1 || sel1 !== 2'd0) begin err++; $display("FAIL bypass_sel got=%0d/%0d exp=1/0", sel0, sel1); end
      $display("bypass: sel0=%0d sel1=%0d", sel0, sel1);
      idle(3);
   endtask

   task automatic test_priority();
      drive(1, 5'd1, 5'd1, 2'b00, 5'd7, 1, 0); tick();   // older x7
      drive(1, 5'd2, 5'd2, 2'b00, 5'd7, 1, 0); tick();   // younger x7
      drive(1, 5'd7, 5'd0, 2'b01, 5'd9, 0, 0); tick();   // reader
      vec++; if (sel0 !== 2'd1) begin err++; $display("FAIL prio_youngest got=%0d exp=1", sel0); end
      $display("priority youngest: sel0=%0d", sel0);
      idle(3);
      drive(1, 5'd0, 5'd0, 2'b00, 5'd7, 1, 0); tick();   // x7
      drive(1, 5'd0, 5'd0, 2'b00, 5'd9, 1, 0); tick();   // x9
      drive(1, 5'd0, 5'd7, 2'b10, 5'd1, 0, 0); tick();   // reader src1=x7
      vec++; if (sel1 !== 2'd2 || sel0 !== 2'd0) begin err++; $display("FAIL prio_two_ahead got=%0d/%0d exp=0/2", sel0, sel1); end
      $display("priority two ahead: sel1=%0d", sel1);
      idle(3);
      drive(1, 5'd0, 5'd0, 2'b00, 5'd7, 1, 0); tick();
      drive(1, 5'd0, 5'd0, 2'b00, 5'd9, 1, 0); tick();
      drive(1, 5'd0, 5'd0, 2'b00, 5'd9, 1, 0); tick();
      drive(1, 5'd7, 5'd0, 2'b01, 5'd1, 0, 0); tick();   // x7 writer out of range
      vec++; if (sel0 !== 2'd0) begin err++; $display("FAIL prio_out_of_range got=%0d exp=0", sel0); end
      $display("priority three ahead: sel0=%0d", sel0);
      idle(3);
   endtask

   task automatic test_gating();
      drive(1, 5'd1, 5'd1, 2'b00, 5'd0, 1, 1); tick();   // load to x0
      drive(1, 5'd0, 5'd0, 2'b11, 5'd2, 1, 0);           // reader x0, x0
      #1 vec++; if (stall_id !== 1'b0) begin err++; $display("FAIL x0_stall got=%b exp=0", stall_id); end
      tick();
      vec++; if (ex_fwd_sel !== 4'd0) begin err++; $display("FAIL x0_sel got=%b exp=0000", ex_fwd_sel); end
      $display("x0: sel=%b stall=%b", ex_fwd_sel, stall_id);
      idle(3);
      drive(1, 5'd1, 5'd2, 2'b11, 5'd3, 0, 0); tick();   // store, rd field x3
      drive(1, 5'd4, 5'd3, 2'b11, 5'd5, 1, 0); tick();   // reader src1=x3
      vec++; if (sel1 !== 2'd0) begin err++; $display("FAIL regwrite_gate got=%0d exp=0", sel1); end
      $display("regwrite gate: sel1=%0d", sel1);
      idle(3);
      drive(1, 5'd1, 5'd1, 2'b00, 5'd8, 1, 0); tick();   // writer x8
      drive(1, 5'd8, 5'd8, 2'b00, 5'd5, 1, 0); tick();   // x8 fields but unused
      vec++; if (ex_fwd_sel !== 4'd0) begin err++; $display("FAIL unused_src got=%b exp=0000", ex_fwd_sel); end
      $display("unused src: sel=%b", ex_fwd_sel);
      idle(3);
   endtask

   task automatic test_load_use();
      drive(1, 5'd2, 5'd0, 2'b01, 5'd4, 1, 1); tick();   // lw x4
      drive(1, 5'd1, 5'd4, 2'b11, 5'd6, 1, 0);           // add rs2=x4
      #1;
      vec++; if (stall_id !== 1'b1) begin err++; $display("FAIL lu_stall got=%b exp=1", stall_id); end
      vec++; if (stall_cnt !== 2'd0) begin err++; $display("FAIL lu_cnt_before got=%0d exp=0", stall_cnt); end
      tick();                                             // ID held, bubble into EX
      vec++; if (stall_id !== 1'b0 || ex_fwd_sel !== 4'd0) begin err++; $display("FAIL lu_bubble stall=%b sel=%b exp 0/0000", stall_id, ex_fwd_sel); end
      vec++; if (stall_cnt !== 2'd1) begin err++; $display("FAIL lu_cnt_after got=%0d exp=1", stall_cnt); end
      tick();
      vec++; if (sel1 !== 2'd2 || sel0 !== 2'd0) begin err++; $display("FAIL lu_sel got=%0d/%0d exp=0/2", sel0, sel1); end
      $display("load-use: sel1=%0d cnt=%0d", sel1, stall_cnt);
      idle(3);
   endtask

   task automatic test_flush_hold();
      drive(1, 5'd2, 5'd0, 2'b01, 5'd4, 1, 1); tick();   // lw x4
      drive(1, 5'd4, 5'd0, 2'b01, 5'd6, 1, 0);
      flush = 1'b1;
      #1 vec++; if (stall_id !== 1'b0) begin err++; $display("FAIL flush_prio got=%b exp=0", stall_id); end
      tick();
      flush = 1'b0;
      #1;
      vec++; if (stall_id !== 1'b0 || stall_cnt !== 2'd1) begin err++; $display("FAIL flush_bubble stall=%b cnt=%0d exp 0/1", stall_id, stall_cnt); end
      drive(1, 5'd1, 5'd1, 2'b00, 5'd10, 1, 0);          // writer x10, flushed
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(1, 5'd10, 5'd0, 2'b01, 5'd2, 0, 0); tick();
      vec++; if (sel0 !== 2'd0) begin err++; $display("FAIL flushed_writer got=%0d exp=0", sel0); end
      $display("flush: stall=%b sel0=%0d", stall_id, sel0);
      idle(3);
      drive(1, 5'd1, 5'd1, 2'b00, 5'd11, 1, 0); tick();  // writer x11
      drive(1, 5'd11, 5'd0, 2'b01, 5'd12, 1, 1); tick(); // lw x12 reads x11
      vec++; if (sel0 !== 2'd1) begin err++; $display("FAIL hold_pre_sel got=%0d exp=1", sel0); end
      drive(1, 5'd3, 5'd12, 2'b11, 5'd13, 1, 0);         // reader of x12
      pipe_hold = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         vec++;
         if (stall_id !== 1'b1 || sel0 !== 2'd1 || stall_cnt !== 2'd1) begin
            err++; $display("FAIL hold_cycle%0d stall=%b sel0=%0d cnt=%0d exp 1/1/1", i, stall_id, sel0, stall_cnt);
         end
         $display("hold cycle %0d: stall=%b sel0=%0d cnt=%0d", i, stall_id, sel0, stall_cnt);
         tick();
      end
      pipe_hold = 1'b0;
      #1 vec++; if (stall_id !== 1'b1 || stall_cnt !== 2'd1) begin err++; $display("FAIL hold_release stall=%b cnt=%0d exp 1/1", stall_id, stall_cnt); end
      tick();
      vec++; if (stall_cnt !== 2'd2 || ex_fwd_sel !== 4'd0) begin err++; $display("FAIL hold_resume cnt=%0d sel=%b exp 2/0000", stall_cnt, ex_fwd_sel); end
      tick();
      vec++; if (sel1 !== 2'd2 || sel0 !== 2'd0) begin err++; $display("FAIL hold_consumer got=%0d/%0d exp=0/2", sel0, sel1); end
      $display("hold resume: sel1=%0d cnt=%0d", sel1, stall_cnt);
      idle(3);
   endtask

   task automatic test_saturate();
      for (int n = 0; n < 2; n++) begin
         drive(1, 5'd0, 5'd0, 2'b00, 5'd20, 1, 1); tick();
         drive(1, 5'd20, 5'd0, 2'b01, 5'd21, 1, 0);
         #1 vec++; if (stall_id !== 1'b1) begin err++; $display("FAIL sat_stall%0d got=%b exp=1", n, stall_id); end
         tick();
         vec++; if (stall_cnt !== 2'd3) begin err++; $display("FAIL sat_cnt%0d got=%0d exp=3", n, stall_cnt); end
         $display("saturate %0d: cnt=%0d", n, stall_cnt);
         idle(3);
      end
   endtask

   task automatic test_async_reset();
      drive(1, 5'd0, 5'd0, 2'b00, 5'd13, 1, 0); tick();
      drive(1, 5'd0, 5'd0, 2'b00, 5'd14, 1, 0); tick();
      drive(1, 5'd14, 5'd13, 2'b11, 5'd1, 0, 0); tick();
      vec++; if (sel0 !== 2'd1 || sel1 !== 2'd2) begin err++; $display("FAIL full_sel got=%0d/%0d exp=1/2", sel0, sel1); end
      drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      vec++; if (ex_fwd_sel !== 4'd0 || stall_id !== 1'b0 || stall_cnt !== 2'd0) begin
         err++; $display("FAIL async_reset sel=%b stall=%b cnt=%0d exp 0000/0/0", ex_fwd_sel, stall_id, stall_cnt);
      end
      $display("async reset: sel=%b stall=%b cnt=%0d", ex_fwd_sel, stall_id, stall_cnt);
      #1 rst_n = 1'b1;
      drive(1, 5'd14, 5'd0, 2'b01, 5'd1, 0, 0); tick();
      vec++; if (sel0 !== 2'd0) begin err++; $display("FAIL post_reset_s1 got=%0d exp=0", sel0); end
      drive(1, 5'd13, 5'd0, 2'b01, 5'd1, 0, 0); tick();
      vec++; if (sel0 !== 2'd0) begin err++; $display("FAIL post_reset_s2 got=%0d exp=0", sel0); end
      $display("post reset: sel0=%0d", sel0);
      idle(1);
   endtask

   initial begin
      vec = 0;
      err = 0;
      test_reset();
      test_bypass();
      test_priority();
      test_gating();
      test_load_use();
      test_flush_hold();
      test_saturate();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
